// File: rtl/mdu_issue_ctrl_pkg.sv
// Shared definitions for the MDU issue/stall controller: op codes, latency counter
// width and the occupancy state type.
package mdu_issue_ctrl_pkg;

   localparam int OP_W     = 6;
   localparam int MD_LAT_W = 4;

   // instr_type encodings shared across the pipeline
   localparam logic [OP_W-1:0] OP_NOP   = 6'h00;
   localparam logic [OP_W-1:0] OP_ADDU  = 6'h01;
   localparam logic [OP_W-1:0] OP_MULT  = 6'h18;
   localparam logic [OP_W-1:0] OP_MULTU = 6'h19;
   localparam logic [OP_W-1:0] OP_DIV   = 6'h1a;
   localparam logic [OP_W-1:0] OP_DIVU  = 6'h1b;
   localparam logic [OP_W-1:0] OP_MADD  = 6'h1c;
   localparam logic [OP_W-1:0] OP_MFHI  = 6'h10;
   localparam logic [OP_W-1:0] OP_MFLO  = 6'h12;
   localparam logic [OP_W-1:0] OP_MTHI  = 6'h11;
   localparam logic [OP_W-1:0] OP_MTLO  = 6'h13;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } md_state_e;

endpackage

// File: rtl/mdu_issue_ctrl_if.sv
// Pipeline-side view of the MDU issue controller: E/D-stage inputs, MDU issue
// lines, stall, profiling counter and the occupancy state for debug.
interface mdu_issue_ctrl_if
   import mdu_issue_ctrl_pkg::*;
#(
   parameter int OPW = OP_W
);
   // e_valid qualifies e_type for exactly the current cycle; an op is accepted
   // (mdu_start / mdu_op != NOP) only in a cycle where e_valid=1, e_flush=0 and
   // the MDU is idle. There is no back-pressure: refusal is signalled by stall_d.
   logic            d_is_md;
   logic            e_valid;
   logic [OPW-1:0]  e_type;
   logic            e_flush;
   logic [OPW-1:0]  mdu_op;
   logic            mdu_start;
   logic            md_busy;
   logic            stall_d;
   logic            proto_err;
   logic [31:0]     stall_cnt;
   md_state_e       state;

   modport master (
      output d_is_md, e_valid, e_type, e_flush,
      input  mdu_op, mdu_start, md_busy, stall_d, proto_err, stall_cnt, state
   );

   modport slave (
      input  d_is_md, e_valid, e_type, e_flush,
      output mdu_op, mdu_start, md_busy, stall_d, proto_err, stall_cnt, state
   );

endinterface

// File: rtl/mdu_lat_counter.sv
// Down-counter tracking remaining MDU busy cycles; loaded on issue, decrements
// to zero and then holds.
module mdu_lat_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic [W-1:0] count,
   output logic         zero
);

   logic [W-1:0] count_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_val;
      end else if (dec && (count_q != '0)) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign count = count_q;
   assign zero  = (count_q == '0);

endmodule

// File: rtl/mdu_issue_ctrl.sv
// MDU issue/stall controller: gates E-stage MD ops onto the MDU, tracks MDU
// occupancy, stalls D-stage MD instrs and counts stall cycles.
module mdu_issue_ctrl
   import mdu_issue_ctrl_pkg::*;
#(
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10,
   parameter int OPW        = OP_W
) (
   input  logic            clk,
   input  logic            reset,
   mdu_issue_ctrl_if.slave bus
);

   md_state_e           state_q;
   md_state_e           state_d;
   logic                is_md;
   logic                is_start;
   logic                is_div;
   logic                issue_ok;
   logic                escape;
   logic                mdu_start;
   logic                stall_d;
   logic [MD_LAT_W-1:0] load_val;
   logic [MD_LAT_W-1:0] count;
   logic                cnt_zero;
   logic                proto_err_q;
   logic [31:0]         stall_cnt_q;

   assign is_start = bus.e_type inside {OPW'(OP_MULT), OPW'(OP_MULTU), OPW'(OP_MADD),
                                        OPW'(OP_DIV), OPW'(OP_DIVU)};
   assign is_md    = is_start | (bus.e_type inside {OPW'(OP_MFHI), OPW'(OP_MFLO),
                                                    OPW'(OP_MTHI), OPW'(OP_MTLO)});
   assign is_div   = bus.e_type inside {OPW'(OP_DIV), OPW'(OP_DIVU)};
   assign load_val = is_div ? MD_LAT_W'(DIV_CYCLES) : MD_LAT_W'(MUL_CYCLES);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Gating on reset keeps the issue lines quiet while reset is held.
   always_comb begin
      state_d  = state_q;
      issue_ok = 1'b0;
      escape   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            issue_ok = reset & bus.e_valid & ~bus.e_flush;
            if (issue_ok && is_start) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            escape = reset & bus.e_valid & ~bus.e_flush & is_md;
            if (count == MD_LAT_W'(1)) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign mdu_start = issue_ok & is_start;
   assign stall_d   = bus.d_is_md & ((state_q == ST_RUN) | mdu_start);

   mdu_lat_counter #(
      .W (MD_LAT_W)
   ) u_lat (
      .clk      (clk),
      .reset    (reset),
      .load     (mdu_start),
      .load_val (load_val),
      .dec      (~cnt_zero),
      .count    (count),
      .zero     (cnt_zero)
   );

   // An MD op reaching E while busy means the stall was bypassed upstream.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         proto_err_q <= 1'b0;
      end else if (escape) begin
         proto_err_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_q <= '0;
      end else if (stall_d && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign bus.mdu_op    = (issue_ok && is_md) ? bus.e_type : OPW'(OP_NOP);
   assign bus.mdu_start = mdu_start;
   assign bus.md_busy   = (state_q == ST_RUN);
   assign bus.stall_d   = stall_d;
   assign bus.proto_err = proto_err_q;
   assign bus.stall_cnt = stall_cnt_q;
   assign bus.state     = state_q;

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Bench for mdu_issue_ctrl: directed pipeline scenarios, a cycle-level occupancy
// model checked every cycle, and hand-computed literal checks per scenario.
module tb_mdu_issue_ctrl;
   import mdu_issue_ctrl_pkg::*;

   localparam int MUL_N = 5;
   localparam int DIV_N = 10;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   mdu_issue_ctrl_if #(.OPW(OP_W)) bus ();

   mdu_issue_ctrl #(
      .MUL_CYCLES (MUL_N),
      .DIV_CYCLES (DIV_N),
      .OPW        (OP_W)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   int          m_left = 0;
   bit          m_perr = 1'b0;
   logic [31:0] m_cnt  = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int lat_of(input logic [OP_W-1:0] t);
      if (t == OP_MULT || t == OP_MULTU || t == OP_MADD) return MUL_N;
      if (t == OP_DIV || t == OP_DIVU) return DIV_N;
      return 0;
   endfunction

   function automatic bit md_of(input logic [OP_W-1:0] t);
      return (lat_of(t) > 0) || (t == OP_MFHI) || (t == OP_MFLO) ||
             (t == OP_MTHI) || (t == OP_MTLO);
   endfunction

   // Model: remaining busy cycles, sticky error flag, saturating stall count.
   initial begin
      bit          busy_now;
      bit          can;
      bit          x_start;
      bit          x_stall;
      logic [OP_W-1:0] x_op;
      int          n_left;
      bit          n_perr;
      logic [31:0] n_cnt;
      forever begin
         @(negedge clk);
         #4;
         if (!reset) begin
            m_left = 0;
            m_perr = 1'b0;
            m_cnt  = '0;
         end
         busy_now = (m_left > 0);
         can      = reset && bus.e_valid && !bus.e_flush && !busy_now;
         x_start  = can && (lat_of(bus.e_type) > 0);
         x_op     = (can && md_of(bus.e_type)) ? bus.e_type : OP_NOP;
         x_stall  = bus.d_is_md && (busy_now || x_start);
         chk("m_mdu_op", 32'(bus.mdu_op), 32'(x_op));
         chk("m_mdu_start", 32'(bus.mdu_start), 32'(x_start));
         chk("m_md_busy", 32'(bus.md_busy), 32'(busy_now));
         chk("m_stall_d", 32'(bus.stall_d), 32'(x_stall));
         chk("m_proto_err", 32'(bus.proto_err), 32'(m_perr));
         chk("m_stall_cnt", bus.stall_cnt, m_cnt);
         n_left = x_start ? lat_of(bus.e_type) : (busy_now ? m_left - 1 : 0);
         n_perr = m_perr || (reset && bus.e_valid && !bus.e_flush &&
                             md_of(bus.e_type) && busy_now);
         n_cnt  = (x_stall && m_cnt != 32'hFFFF_FFFF) ? m_cnt + 32'd1 : m_cnt;
         @(posedge clk);
         m_left = n_left;
         m_perr = n_perr;
         m_cnt  = n_cnt;
      end
   end

   task automatic cyc(input bit rst, input bit dmd, input bit ev,
                      input logic [OP_W-1:0] ty, input bit fl);
      @(negedge clk);
      reset       = rst;
      bus.d_is_md = dmd;
      bus.e_valid = ev;
      bus.e_type  = ty;
      bus.e_flush = fl;
      #4;
   endtask

   initial begin
      int n;
      bus.d_is_md = 1'b0;
      bus.e_valid = 1'b0;
      bus.e_type  = OP_NOP;
      bus.e_flush = 1'b0;

      // reset held, even with a valid MULT presented
      cyc(0, 0, 0, OP_NOP, 0);
      chk("rst_busy", 32'(bus.md_busy), 32'd0);
      chk("rst_cnt", bus.stall_cnt, 32'd0);
      chk("rst_state", 32'(bus.state), 32'(ST_IDLE));
      cyc(0, 1, 1, OP_MULT, 0);
      chk("rst_op", 32'(bus.mdu_op), 32'(OP_NOP));
      chk("rst_start", 32'(bus.mdu_start), 32'd0);
      chk("rst_stall", 32'(bus.stall_d), 32'd0);

      // MULT issue with MFLO waiting in D
      cyc(1, 1, 1, OP_MULT, 0);
      chk("s1_start", 32'(bus.mdu_start), 32'd1);
      chk("s1_op", 32'(bus.mdu_op), 32'(OP_MULT));
      chk("s1_stall", 32'(bus.stall_d), 32'd1);
      for (int i = 1; i <= 5; i++) begin
         cyc(1, 1, 0, OP_NOP, 0);
         chk("s1_stall_hold", 32'(bus.stall_d), 32'd1);
      end
      chk("s1_state_run", 32'(bus.state), 32'(ST_RUN));
      cyc(1, 0, 1, OP_MFLO, 0);
      chk("s1_mflo_op", 32'(bus.mdu_op), 32'(OP_MFLO));
      chk("s1_mflo_stall", 32'(bus.stall_d), 32'd0);
      chk("s1_mflo_busy", 32'(bus.md_busy), 32'd0);
      chk("s1_stall_cnt", bus.stall_cnt, 32'd6);

      // DIVU with a non-MD instr in D
      cyc(1, 0, 1, OP_DIVU, 0);
      chk("s2_start", 32'(bus.mdu_start), 32'd1);
      chk("s2_stall", 32'(bus.stall_d), 32'd0);
      n = 0;
      for (int i = 0; i < 12; i++) begin
         cyc(1, 0, 0, OP_NOP, 0);
         if (bus.md_busy === 1'b1) n++;
      end
      chk("s2_busy_len", 32'(n), 32'd10);
      chk("s2_stall_cnt", bus.stall_cnt, 32'd6);

      // flush, pass-through, non-MD and invalid cases
      cyc(1, 1, 1, OP_MULT, 1);
      chk("s3_flush_op", 32'(bus.mdu_op), 32'(OP_NOP));
      chk("s3_flush_start", 32'(bus.mdu_start), 32'd0);
      cyc(1, 0, 0, OP_NOP, 0);
      chk("s3_flush_busy", 32'(bus.md_busy), 32'd0);
      cyc(1, 0, 1, OP_MTLO, 0);
      chk("s3_mtlo_op", 32'(bus.mdu_op), 32'(OP_MTLO));
      chk("s3_mtlo_start", 32'(bus.mdu_start), 32'd0);
      cyc(1, 0, 1, OP_ADDU, 0);
      chk("s3_addu_op", 32'(bus.mdu_op), 32'(OP_NOP));
      cyc(1, 0, 0, OP_MULT, 0);
      chk("s3_inval_op", 32'(bus.mdu_op), 32'(OP_NOP));
      cyc(1, 0, 1, OP_MADD, 0);
      chk("s3_madd_start", 32'(bus.mdu_start), 32'd1);
      repeat (5) cyc(1, 0, 0, OP_NOP, 0);

      // reset in the third cycle of a DIV
      cyc(1, 0, 1, OP_DIV, 0);
      cyc(1, 0, 0, OP_NOP, 0);
      cyc(1, 0, 0, OP_NOP, 0);
      chk("s4_busy_before", 32'(bus.md_busy), 32'd1);
      @(negedge clk);
      #2 reset = 1'b0;
      #1 chk("s4_busy_async", 32'(bus.md_busy), 32'd0);
      #1;
      cyc(1, 0, 1, OP_MTHI, 0);
      chk("s4_mthi_op", 32'(bus.mdu_op), 32'(OP_MTHI));
      chk("s4_cnt_clr", bus.stall_cnt, 32'd0);

      // DIV forced into E while busy
      cyc(1, 0, 1, OP_DIV, 0);
      cyc(1, 0, 1, OP_DIV, 0);
      chk("s5_esc_op", 32'(bus.mdu_op), 32'(OP_NOP));
      chk("s5_esc_start", 32'(bus.mdu_start), 32'd0);
      cyc(1, 0, 0, OP_NOP, 0);
      chk("s5_perr_set", 32'(bus.proto_err), 32'd1);
      repeat (12) cyc(1, 0, 0, OP_NOP, 0);
      chk("s5_perr_sticky", 32'(bus.proto_err), 32'd1);
      chk("s5_idle", 32'(bus.md_busy), 32'd0);
      cyc(1, 0, 1, OP_MFHI, 0);
      chk("s5_mfhi_op", 32'(bus.mdu_op), 32'(OP_MFHI));
      cyc(0, 0, 0, OP_NOP, 0);
      chk("s5_perr_clr", 32'(bus.proto_err), 32'd0);

      // stall counter saturation from a preset near the top
      cyc(1, 0, 0, OP_NOP, 0);
      @(negedge clk);
      force dut.stall_cnt_q = 32'hFFFF_FFFC;
      m_cnt = 32'hFFFF_FFFC;
      #4;
      @(negedge clk);
      release dut.stall_cnt_q;
      #4;
      chk("s6_preset", bus.stall_cnt, 32'hFFFF_FFFC);
      cyc(1, 1, 1, OP_MULTU, 0);
      repeat (5) cyc(1, 1, 0, OP_NOP, 0);
      cyc(1, 0, 0, OP_NOP, 0);
      chk("s6_saturate", bus.stall_cnt, 32'hFFFF_FFFF);
      chk("s6_idle", 32'(bus.md_busy), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
